// File: rtl/mem_cycle_ctrl.sv
// Memory cycle controller: sequences SRAM strobes and bridge enables through SETUP/ACCESS/HOLD.
// Optional MEMCTRL_READY_EN adds a mem_ready input that stretches ACCESS after the wait count.
module mem_cycle_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              done,
    output logic [7:0]        rd_data,
    input  logic [7:0]        mem_data_in,
`ifdef MEMCTRL_READY_EN
    input  logic              mem_ready,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              a_membridge_n,
    output logic              d_membridge_n
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        rd_q, rd_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              a_n_q, a_n_d;
    logic              d_n_q, d_n_d;
    logic              access_ok;

`ifdef MEMCTRL_READY_EN
    assign access_ok = mem_ready;
`else
    assign access_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StSetup;
                    write_d = req_write;
                    addr_d  = req_addr;
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = WaitCnt;
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (access_ok) begin
                    state_d = StHold;
                    if (!write_q) begin
                        rd_d = mem_data_in;
                    end
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they appear registered in the same cycle.
        ready_d = (state_d == StIdle);
        done_d  = (state_d == StHold);
        oe_n_d  = !(!write_d && (state_d == StSetup || state_d == StAccess));
        a_n_d   = !(!write_d && (state_d == StAccess));
        we_n_d  = !(write_d && (state_d == StAccess));
        d_n_d   = !(write_d && (state_d == StSetup || state_d == StAccess || state_d == StHold));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= 4'd0;
            rd_q    <= 8'h00;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            a_n_q   <= 1'b1;
            d_n_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            a_n_q   <= a_n_d;
            d_n_q   <= d_n_d;
        end
    end

    assign req_ready     = ready_q;
    assign done          = done_q;
    assign rd_data       = rd_q;
    assign mem_addr      = addr_q;
    assign mem_oe_n      = oe_n_q;
    assign mem_we_n      = we_n_q;
    assign a_membridge_n = a_n_q;
    assign d_membridge_n = d_n_q;

endmodule
